// File: rtl/tmds_period_scheduler.sv
// TMDS period sequencer: delays pixel data/syncs by L cycles and schedules
// control, preamble, guard band and active video periods to line up with them.
module tmds_period_scheduler #(
    parameter int DATA_W       = 24,
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2,
    parameter int MIN_CTRL     = 12
) (
    input  logic              pixel_clk,
    input  logic              rst,
    input  logic              hdmi_mode,
    input  logic              de_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [DATA_W-1:0] rgb_in,
    output logic              de_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic [DATA_W-1:0] rgb_out,
    output logic [1:0]        period,
    output logic [3:0]        ctl,
    output logic              err_short
);

    localparam int L       = PREAMBLE_LEN + GUARD_LEN + 1;
    localparam int PW      = DATA_W + 3;
    localparam int SEQ_MAX = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam int CC_W    = $clog2(MIN_CTRL + 1);

    localparam logic [1:0] ST_CTRL  = 2'd0;
    localparam logic [1:0] ST_PRE   = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;
    localparam logic [1:0] ST_VIDEO = 2'd3;

    // Stage 0 is the input register; stage L drives the outputs, so data
    // sampled at edge n appears on the outputs at edge n+L.
    logic [PW-1:0] pipe_q [0:L];
    logic [PW-1:0] pipe_d [0:L];

    logic              hdmi_s_q, hdmi_s_d;
    logic [1:0]        state_q, state_d;
    logic [SEQ_W-1:0]  seq_cnt_q, seq_cnt_d;
    logic [CC_W-1:0]   ctrl_cnt_q, ctrl_cnt_d;
    logic              err_q, err_d;
    logic [3:0]        ctl_q, ctl_d;

    logic              rise;
    logic              de_next;

    always_comb begin
        pipe_d[0] = {de_in, hsync_in, vsync_in, rgb_in};
        for (int i = 1; i <= L; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign hdmi_s_d = hdmi_mode;
    assign rise     = pipe_q[0][PW-1] & ~pipe_q[1][PW-1];
    assign de_next  = pipe_q[L-1][PW-1];

    always_comb begin
        state_d   = state_q;
        seq_cnt_d = seq_cnt_q;
        case (state_q)
            ST_CTRL: begin
                // Data already reaching the outputs takes precedence over a new edge.
                if (de_next) begin
                    state_d = ST_VIDEO;
                end else if (rise && hdmi_s_q) begin
                    state_d   = ST_PRE;
                    seq_cnt_d = SEQ_W'(PREAMBLE_LEN - 1);
                end
            end
            ST_PRE: begin
                if (seq_cnt_q == '0) begin
                    state_d   = ST_GUARD;
                    seq_cnt_d = SEQ_W'(GUARD_LEN - 1);
                end else begin
                    seq_cnt_d = seq_cnt_q - SEQ_W'(1);
                end
            end
            ST_GUARD: begin
                if (seq_cnt_q == '0) begin
                    state_d = de_next ? ST_VIDEO : ST_CTRL;
                end else begin
                    seq_cnt_d = seq_cnt_q - SEQ_W'(1);
                end
            end
            ST_VIDEO: begin
                if (!de_next) begin
                    state_d = ST_CTRL;
                end
            end
            default: state_d = ST_CTRL;
        endcase
    end

    always_comb begin
        ctrl_cnt_d = ctrl_cnt_q;
        if (state_d != ST_CTRL) begin
            ctrl_cnt_d = '0;
        end else if (state_q == ST_CTRL && ctrl_cnt_q < CC_W'(MIN_CTRL)) begin
            ctrl_cnt_d = ctrl_cnt_q + CC_W'(1);
        end
    end

    assign err_d = err_q | (rise & ((state_q != ST_CTRL) | (ctrl_cnt_q < CC_W'(MIN_CTRL))));
    assign ctl_d = (state_d == ST_PRE) ? 4'b0001 : 4'b0000;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            for (int i = 0; i <= L; i++) begin
                pipe_q[i] <= '0;
            end
            hdmi_s_q   <= 1'b0;
            state_q    <= ST_CTRL;
            seq_cnt_q  <= '0;
            ctrl_cnt_q <= '0;
            err_q      <= 1'b0;
            ctl_q      <= 4'b0000;
        end else begin
            for (int i = 0; i <= L; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            hdmi_s_q   <= hdmi_s_d;
            state_q    <= state_d;
            seq_cnt_q  <= seq_cnt_d;
            ctrl_cnt_q <= ctrl_cnt_d;
            err_q      <= err_d;
            ctl_q      <= ctl_d;
        end
    end

    assign de_out    = pipe_q[L][PW-1];
    assign hsync_out = pipe_q[L][PW-2];
    assign vsync_out = pipe_q[L][PW-3];
    assign rgb_out   = pipe_q[L][DATA_W-1:0];
    assign period    = state_q;
    assign ctl       = ctl_q;
    assign err_short = err_q;

endmodule

// File: tb/tb_tmds_period_scheduler.sv
// Directed bench for tmds_period_scheduler: period sequencing, delay line,
// short-blanking detection and mid-preamble reset.
module tb_tmds_period_scheduler;

    localparam int DATA_W = 24;
    localparam int L      = 11;

    logic              pixel_clk = 1'b0;
    logic              rst       = 1'b1;
    logic              hdmi_mode = 1'b0;
    logic              de_in     = 1'b0;
    logic              hsync_in  = 1'b0;
    logic              vsync_in  = 1'b0;
    logic [DATA_W-1:0] rgb_in    = '0;
    logic              de_out, hsync_out, vsync_out;
    logic [DATA_W-1:0] rgb_out;
    logic [1:0]        period;
    logic [3:0]        ctl;
    logic              err_short;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    tmds_period_scheduler dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .hdmi_mode (hdmi_mode),
        .de_in     (de_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .rgb_in    (rgb_in),
        .de_out    (de_out),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .rgb_out   (rgb_out),
        .period    (period),
        .ctl       (ctl),
        .err_short (err_short)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Advance one edge, then drive a fresh rgb/sync pattern derived from the edge count.
    task automatic step();
        logic [31:0] c;
        @(posedge pixel_clk);
        #1;
        cyc++;
        c        = cyc;
        rgb_in   = c[DATA_W-1:0];
        hsync_in = c[2];
        vsync_in = c[5];
    endtask

    function automatic logic pat(input int j, input int len1, input int gap, input int len2);
        return (j >= 0 && j < len1) ||
               (len2 > 0 && j >= len1 + gap && j < len1 + gap + len2);
    endfunction

    // k counts edges after the one that first samples de_in high (k=0).
    task automatic run_seq(input logic hdmi, input int len1, input int gap,
                           input int len2, input logic exp_err);
        int          total;
        logic        exp_de;
        logic [1:0]  exp_p;
        logic [31:0] x;
        total     = L + len1 + gap + len2 + 2;
        hdmi_mode = hdmi;
        for (int k = 0; k <= total; k++) begin
            de_in = pat(k, len1, gap, len2);
            if (k == 3) hdmi_mode = ~hdmi;
            step();
            exp_de = (k >= L) && pat(k - L, len1, gap, len2);
            if (exp_de)                            exp_p = 2'd3;
            else if (hdmi && k >= 1 && k <= 8)     exp_p = 2'd1;
            else if (hdmi && (k == 9 || k == 10))  exp_p = 2'd2;
            else                                   exp_p = 2'd0;
            x = cyc - 12;
            check("period", 32'(period), 32'(exp_p));
            check("de_out", 32'(de_out), 32'(exp_de));
            check("ctl", 32'(ctl), (exp_p == 2'd1) ? 32'h1 : 32'h0);
            check("rgb_out", 32'(rgb_out), x & 32'hFF_FFFF);
            check("hsync_out", 32'(hsync_out), 32'(x[2]));
            check("vsync_out", 32'(vsync_out), 32'(x[5]));
        end
        check("err_short", 32'(err_short), 32'(exp_err));
        de_in = 1'b0;
        for (int i = 0; i < 14; i++) step();
    endtask

    initial begin
        logic [1:0] ep;
        // Reset held three cycles with idle inputs
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("rst_period", 32'(period), 32'h0);
        check("rst_de_out", 32'(de_out), 32'h0);
        check("rst_rgb", 32'(rgb_out), 32'h0);
        check("rst_sync", {30'b0, hsync_out, vsync_out}, 32'h0);
        check("rst_ctl", 32'(ctl), 32'h0);
        check("rst_err", 32'(err_short), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("idle_err", 32'(err_short), 32'h0);

        run_seq(1'b1, 16, 0, 0, 1'b0);   // HDMI burst
        run_seq(1'b0, 16, 0, 0, 1'b0);   // DVI burst
        run_seq(1'b1, 3, 0, 0, 1'b0);    // pulse shorter than L
        run_seq(1'b1, 16, 5, 8, 1'b1);   // insufficient blanking

        // Reset during preamble, de_in held high across it
        hdmi_mode = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            de_in = 1'b1;
            step();
            check("pre_rst_period", 32'(period), (k == 0) ? 32'h0 : 32'h1);
        end
        rst = 1'b1;
        step();
        check("mid_rst_period", 32'(period), 32'h0);
        check("mid_rst_de_out", 32'(de_out), 32'h0);
        check("mid_rst_err", 32'(err_short), 32'h0);
        check("mid_rst_ctl", 32'(ctl), 32'h0);
        rst = 1'b0;
        for (int m = 1; m <= 12; m++) begin
            step();
            if (m == 1)       ep = 2'd0;
            else if (m <= 9)  ep = 2'd1;
            else if (m <= 11) ep = 2'd2;
            else              ep = 2'd3;
            check("post_rst_period", 32'(period), 32'(ep));
            check("post_rst_de_out", 32'(de_out), (m == 12) ? 32'h1 : 32'h0);
            check("post_rst_err", 32'(err_short), (m >= 2) ? 32'h1 : 32'h0);
        end
        de_in = 1'b0;
        for (int i = 0; i < 3; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
